// File: rtl/dco_word_ctrl_if.sv
// Requester/coder-side bundle of dco_word_ctrl: enable, loop and calibration
// requests in, capacitor word, coder strobe and handshake status out.
interface dco_word_ctrl_if;
    logic       en;
    logic [4:0] loop_word;
    logic       loop_vld;
    logic       cal_req;
    logic [4:0] cal_word;
    logic       cal_ack;
    logic [4:0] word;
    logic       cod_en;
    logic       owner;
    logic       settled;

    modport master (
        output en, loop_word, loop_vld, cal_req, cal_word,
        input  cal_ack, word, cod_en, owner, settled
    );

    modport slave (
        input  en, loop_word, loop_vld, cal_req, cal_word,
        output cal_ack, word, cod_en, owner, settled
    );
endinterface

// File: rtl/dco_word_ctrl.sv
// DCO capacitor-word sequencer: arbitrates loop vs calibration ownership and steps the word on ticks.
// Define DCO_WORD_SLEW_EN for one-LSB-per-tick slewing; otherwise a tick loads the target directly.
module dco_word_ctrl #(
    parameter int MAX      = 25,
    parameter int STEP_DIV = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dco_word_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_LOOP, S_CAL_SLEW, S_CAL_HOLD, S_RETURN} state_t;

    localparam logic [3:0] TCNT_LAST = 4'(STEP_DIV - 1);
    localparam logic [4:0] MAX_W     = 5'(MAX);

    state_t     state, state_nxt;
    logic [3:0] tcnt;
    logic       sync;
    logic       tick;
    logic [4:0] loop_cap, loop_src, loop_tgt, cal_tgt;
    logic [4:0] tgt, tgt_nxt;
    logic [4:0] word_q, word_nxt;
    logic       cod_en_q, cal_ack_q, settled_q;

    function automatic logic [4:0] clamp(input logic [4:0] w);
        return (w > MAX_W) ? MAX_W : w;
    endfunction

    function automatic logic [4:0] step_toward(input logic [4:0] w, input logic [4:0] t);
`ifdef DCO_WORD_SLEW_EN
        if (w < t)      return w + 5'd1;
        else if (w > t) return w - 5'd1;
        else            return w;
`else
        return (w == t) ? w : t;
`endif
    endfunction

    function automatic logic is_cal(input state_t s);
        return (s == S_CAL_SLEW) || (s == S_CAL_HOLD);
    endfunction

    assign tick = bus.en && (tcnt == TCNT_LAST);

    // A capture taken on this tick is already the loop target for this tick's step.
    assign loop_src = (tick && bus.loop_vld) ? bus.loop_word : loop_cap;
    assign loop_tgt = clamp(loop_src);
    assign cal_tgt  = clamp(bus.cal_word);
    assign tgt      = is_cal(state) ? cal_tgt : loop_tgt;
    assign word_nxt = tick ? step_toward(word_q, tgt) : word_q;

    always_comb begin
        state_nxt = state;
        if (bus.en) begin
            unique case (state)
                S_LOOP:     if (bus.cal_req) state_nxt = S_CAL_SLEW;
                S_CAL_SLEW: if (!bus.cal_req) state_nxt = S_RETURN;
                            else if (word_q == cal_tgt) state_nxt = S_CAL_HOLD;
                S_CAL_HOLD: if (!bus.cal_req) state_nxt = S_RETURN;
                S_RETURN:   if (bus.cal_req) state_nxt = S_CAL_SLEW;
                            else if (word_q == loop_tgt) state_nxt = S_LOOP;
                default:    state_nxt = S_LOOP;
            endcase
        end
    end

    // Status flags are judged against the word and owner that exist after this edge.
    assign tgt_nxt = is_cal(state_nxt) ? cal_tgt : loop_tgt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOOP;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt      <= 4'd0;
            sync      <= 1'b1;
            word_q    <= 5'd0;
            loop_cap  <= 5'd0;
            cod_en_q  <= 1'b0;
            cal_ack_q <= 1'b0;
            settled_q <= 1'b1;
        end else begin
            cod_en_q <= tick && ((word_nxt != word_q) || sync);
            if (bus.en) begin
                tcnt      <= (tcnt == TCNT_LAST) ? 4'd0 : tcnt + 4'd1;
                word_q    <= word_nxt;
                cal_ack_q <= (state_nxt == S_CAL_HOLD) && (word_nxt == cal_tgt);
                settled_q <= (word_nxt == tgt_nxt);
                if (tick) sync <= 1'b0;
                if (tick && bus.loop_vld) loop_cap <= bus.loop_word;
            end
        end
    end

    assign bus.word    = word_q;
    assign bus.cod_en  = cod_en_q;
    assign bus.cal_ack = cal_ack_q;
    assign bus.settled = settled_q;
    assign bus.owner   = is_cal(state);

endmodule

// File: tb/tb_dco_word_ctrl.sv
// Self-checking bench for dco_word_ctrl: vector table, directed handshake/freeze/reset
// sequences and randomized traffic against a behavioural ownership/slew model.
module tb_dco_word_ctrl;
  localparam int MAX      = 25;
  localparam int STEP_DIV = 4;
`ifdef DCO_WORD_SLEW_EN
  localparam bit SLEW = 1'b1;
`else
  localparam bit SLEW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  dco_word_ctrl_if bus();

  dco_word_ctrl #(.MAX(MAX), .STEP_DIV(STEP_DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the array, whether calibration has arrived, the word and flags.
  int m_word, m_cap, m_cnt;
  bit m_sync, m_own, m_held, m_cod, m_ack, m_set;

  typedef struct {
    bit en;
    bit vld;
    int lw;
    int n;
    int w;
    int cod;
    int set;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_word = 0; m_cap = 0; m_cnt = 0;
    m_sync = 1; m_own = 0; m_held = 0;
    m_cod = 0; m_ack = 0; m_set = 1;
  endtask

  task automatic model_step();
    int lsrc, ltgt, ctgt, tgt, nw;
    bit tick;
    if (!bus.en) begin
      m_cod = 0;
      return;
    end
    tick  = (m_cnt == STEP_DIV - 1);
    m_cnt = (m_cnt + 1) % STEP_DIV;
    lsrc  = (tick && bus.loop_vld) ? int'(bus.loop_word) : m_cap;
    if (tick && bus.loop_vld) m_cap = int'(bus.loop_word);
    ltgt = (lsrc > MAX) ? MAX : lsrc;
    ctgt = (int'(bus.cal_word) > MAX) ? MAX : int'(bus.cal_word);
    tgt  = m_own ? ctgt : ltgt;
    nw   = m_word;
    if (tick) begin
      if (!SLEW)           nw = tgt;
      else if (m_word < tgt) nw = m_word + 1;
      else if (m_word > tgt) nw = m_word - 1;
    end
    if (bus.cal_req) begin
      if (!m_own) begin
        m_own = 1; m_held = 0;
      end else if (!m_held && m_word == ctgt) begin
        m_held = 1;
      end
    end else begin
      m_own = 0; m_held = 0;
    end
    m_cod = tick && ((nw != m_word) || m_sync);
    if (tick) m_sync = 0;
    m_word = nw;
    m_ack  = m_own && m_held && (m_word == ctgt);
    m_set  = (m_word == (m_own ? ctgt : ltgt));
  endtask

  task automatic compare_model();
    check("model_word",    int'(bus.word),    m_word);
    check("model_cod_en",  int'(bus.cod_en),  int'(m_cod));
    check("model_cal_ack", int'(bus.cal_ack), int'(m_ack));
    check("model_owner",   int'(bus.owner),   int'(m_own));
    check("model_settled", int'(bus.settled), int'(m_set));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare_model();
  endtask

  task automatic run_until_word(input int w, input int budget, input string name);
    int k;
    k = 0;
    while (!(int'(bus.word) == w && bus.settled && !bus.owner) && k < budget) begin
      cycle();
      k++;
    end
    check(name, (int'(bus.word) == w && bus.settled) ? 1 : 0, 1);
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_model();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int w0, freeze_bad, k, rise_at, reach_at;
    int seen[$];

    bus.en = 1'b1; bus.loop_vld = 1'b0; bus.loop_word = 5'd0;
    bus.cal_req = 1'b0; bus.cal_word = 5'd0;
    model_reset();

    tbl = '{
      '{1'b1, 1'b0,  0,  3,  0,               0,               1},
      '{1'b1, 1'b0,  0,  1,  0,               1,               1},
      '{1'b1, 1'b0,  0,  4,  0,               0,               1},
      '{1'b1, 1'b1,  7,  4,  SLEW ? 1 : 7,    1,               SLEW ? 0 : 1},
      '{1'b1, 1'b0,  0, 24,  7,               SLEW ? 1 : 0,    1},
      '{1'b1, 1'b0,  0,  4,  7,               0,               1},
      '{1'b1, 1'b1, 31,  4,  SLEW ? 8 : 25,   1,               SLEW ? 0 : 1},
      '{1'b1, 1'b0,  0, 68,  25,              SLEW ? 1 : 0,    1},
      '{1'b1, 1'b0,  0,  8,  25,              0,               1}
    };

    #12;
    check("reset_word",    int'(bus.word),    0);
    check("reset_cod_en",  int'(bus.cod_en),  0);
    check("reset_cal_ack", int'(bus.cal_ack), 0);
    check("reset_owner",   int'(bus.owner),   0);
    check("reset_settled", int'(bus.settled), 1);
    @(posedge clk); #3;
    rst_n = 1'b1;

    // Table: sync pulse, loop slew to 7, saturation at MAX
    for (int i = 0; i < 9; i++) begin
      bus.en = tbl[i].en;
      bus.loop_vld = tbl[i].vld;
      bus.loop_word = 5'(tbl[i].lw);
      for (int c = 0; c < tbl[i].n; c++) cycle();
      check($sformatf("vec%0d_word", i),    int'(bus.word),    tbl[i].w);
      check($sformatf("vec%0d_cod_en", i),  int'(bus.cod_en),  tbl[i].cod);
      check($sformatf("vec%0d_settled", i), int'(bus.settled), tbl[i].set);
      check($sformatf("vec%0d_owner", i),   int'(bus.owner),   0);
      check($sformatf("vec%0d_cal_ack", i), int'(bus.cal_ack), 0);
    end

    // Calibration handshake from word 7 down to 3 and back
    bus.loop_vld = 1'b1; bus.loop_word = 5'd7;
    run_until_word(7, 200, "loop_to_7");
    bus.loop_vld = 1'b0;
    bus.cal_word = 5'd3; bus.cal_req = 1'b1;
    cycle();
    check("cal_owner", int'(bus.owner), 1);
    k = 0; rise_at = -1; reach_at = -1;
    while (!bus.cal_ack && k < 200) begin
      cycle();
      k++;
      if (bus.cod_en) seen.push_back(int'(bus.word));
      if (reach_at < 0 && int'(bus.word) == 3) reach_at = k;
    end
    rise_at = k;
    check("cal_ack_timeout", int'(bus.cal_ack), 1);
    check("cal_word_reached", int'(bus.word), 3);
    check("cal_pulses", seen.size(), SLEW ? 4 : 1);
    if (seen.size() > 0) begin
      check("cal_first_step", seen[0], SLEW ? 6 : 3);
      check("cal_last_step", seen[seen.size()-1], 3);
    end
    check("cal_ack_latency", rise_at - reach_at, 1);
    bus.cal_req = 1'b0;
    cycle();
    check("release_ack", int'(bus.cal_ack), 0);
    check("release_owner", int'(bus.owner), 0);
    run_until_word(7, 200, "return_to_7");

    // Enable freeze mid-slew, then asynchronous reset mid-slew
    bus.loop_vld = 1'b1; bus.loop_word = 5'd20;
    k = 0;
    while (int'(bus.word) == 7 && k < 20) begin cycle(); k++; end
    bus.loop_vld = 1'b0;
    check("freeze_setup_moved", (int'(bus.word) != 7) ? 1 : 0, 1);
    cycle();
    bus.en = 1'b0;
    w0 = int'(bus.word);
    freeze_bad = 0;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (int'(bus.word) != w0 || bus.cod_en) freeze_bad++;
    end
    check("freeze_bad_cycles", freeze_bad, 0);
    bus.en = 1'b1;
    cycle(); cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midslew_reset_word",    int'(bus.word),    0);
    check("midslew_reset_cod_en",  int'(bus.cod_en),  0);
    check("midslew_reset_settled", int'(bus.settled), 1);
    check("midslew_reset_owner",   int'(bus.owner),   0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cycle();
      check($sformatf("post_reset_cod_en_c%0d", c), int'(bus.cod_en), (c == 4) ? 1 : 0);
      check($sformatf("post_reset_word_c%0d", c), int'(bus.word), 0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      bus.loop_vld = ($urandom_range(0, 2) == 0);
      bus.loop_word = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 39) == 0) bus.cal_req = ~bus.cal_req;
      if ($urandom_range(0, 19) == 0) bus.cal_word = 5'($urandom_range(0, 31));
      cycle();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dco_word_ctrl.md
# dco_word_ctrl

Tuning-word sequencer that sits between the ADPLL loop filter, the DCO calibration FSM and the 5x5 row/column capacitor coder. It arbitrates ownership of the 5-bit capacitor word between the two requesters. It slew-limits word changes so the array never jumps more than one unit cell per update, and strobes the coder enable on every update tick.

## Interface
- `MAX`, 25: largest legal word; larger targets clamp to `MAX`.
- `STEP_DIV`, 4: clk cycles per update tick, legal range 1..16.
- `clk`  in  1  DCO-domain clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  block enable; low freezes all state.
- `loop_word`  in  5  target word from loop filter.
- `loop_vld`  in  1  `loop_word` valid; sampled only on a tick.
- `cal_req`  in  1  calibration requests ownership (level).
- `cal_word`  in  5  calibration target word.
- `cal_ack`  out  1  calibration owns the array and word == clamped `cal_word`.
- `word`  out  5  word to coder.
- `cod_en`  out  1  one-cycle coder enable.
- `owner`  out  1  0 = loop, 1 = calibration.
- `settled`  out  1  word == current clamped target.

## Operation
- Tick counter `tcnt`, 4 bits:
  - Counts 0..STEP_DIV-1 while `en`=1 and wraps to 0.
  - `tick` = (`tcnt`==STEP_DIV-1) & `en`.
- Target: `tgt` = min(selected source word, MAX). Loop source is the last `loop_word` captured on a tick with `loop_vld`=1; reset value 0.
- On each tick, step `word` toward `tgt`:
  - `word` < `tgt`: +1.
  - `word` > `tgt`: -1.
  - equal: hold.
  - Arithmetic is 5-bit, unsigned, and never wraps.
- `cod_en` is registered.
  - Pulses for one cycle, in the same cycle the new `word` appears, on every tick where `word` changes.
  - Also pulses on the first tick after reset (`sync` flag, set by reset, cleared by that tick), even if `word` is unchanged, so the coder leaves its reset pattern.
- FSM states: `S_LOOP`, `S_CAL_SLEW`, `S_CAL_HOLD`, `S_RETURN`. Reset state is `S_LOOP`.
  - `S_LOOP`: tgt = loop. `cal_req`=1 -> `S_CAL_SLEW`.
  - `S_CAL_SLEW`: tgt = cal. Loop captures are still taken but not applied.
    - `word`==tgt -> `S_CAL_HOLD`.
    - `cal_req`=0 -> `S_RETURN`.
  - `S_CAL_HOLD`: tgt = cal; `cal_ack`=1 while `word`==tgt.
    - `cal_word` changes: slew continues and `cal_ack` drops until reached.
    - `cal_req`=0 -> `S_RETURN`.
  - `S_RETURN`: tgt = loop.
    - `word`==tgt -> `S_LOOP`.
    - `cal_req`=1 -> `S_CAL_SLEW`.
- `cal_req` has priority over loop on any simultaneous event.
- `owner`=1 in `S_CAL_SLEW` and `S_CAL_HOLD`; 0 otherwise.
- `settled` and `cal_ack` are registered and evaluated against the post-update word.

## Timing
- Reset values:
  - `word`=0, `cod_en`=0, `cal_ack`=0, `owner`=0, `settled`=1.
  - `tcnt`=0, `sync`=1, FSM=`S_LOOP`.
- Reset is asynchronous assert and synchronous-deassert safe. Mid-slew reset returns everything to the reset values immediately; the first tick afterwards pulses `cod_en`.
- First tick after reset occurs STEP_DIV `en` cycles after release.
- A word change is visible STEP_DIV cycles per LSB; a full 0->25 slew takes 25 ticks.
- FSM transitions are evaluated every cycle, not only on ticks.
- `cal_ack` rises in the cycle after `word` reaches `cal_word`, and falls one cycle after `cal_req` drops.
- `en`=0:
  - `tcnt`, FSM, `word` and captures hold.
  - `cod_en` is forced 0.
  - `cal_ack`, `owner` and `settled` hold.

## Configuration
- `DCO_WORD_SLEW_EN` defined: one-LSB-per-tick slewing as above.
- Not defined: on a tick, `word` loads `tgt` directly.
  - `cod_en` still pulses only on change, plus the sync pulse.
  - The calibration handshake is unchanged; `S_CAL_SLEW` lasts one tick.

## Test plan
- Reset release, `en`=1, STEP_DIV=4, no `loop_vld` -> `cod_en` pulse 4 cycles after release with `word`=0, then no further pulses.
- `loop_word`=7 valid -> `word` 1..7 on 7 consecutive ticks, 7 `cod_en` pulses, `settled`=1 after the last.
- `loop_word`=31 -> `word` saturates at 25; `settled`=1; never reaches 26.
- At `word`=7, `cal_req`=1, `cal_word`=3:
  - `owner`=1; `word` 6,5,4,3; then `cal_ack`=1.
  - Drop `cal_req`: `cal_ack`=0 next cycle; `word` 4..7, `owner`=0, `S_LOOP`.
- Drop `en` for 10 cycles mid-slew, then pull `rst_n` low mid-slew:
  - `word` frozen with no `cod_en` while disabled.
  - Reset clears `word` to 0 asynchronously; a sync pulse follows.
- Build without `DCO_WORD_SLEW_EN`, `loop_word`=20 -> single tick jumps `word` 0->20 with one `cod_en`.
